// File: rtl/fpu_add_issue_ctrl.sv
// Issue controller sitting between the core FP-add request channel and a
// multi-cycle adder: resolves rounding mode, issues once, waits with timeout.
module fpu_add_issue_ctrl #(
    parameter int PARAM_Fp_size = 32,
    parameter int TIMEOUT       = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     op_valid,
    output logic                     op_ready,
    input  logic [4:0]               op_rd,
    input  logic                     op_sub,
    input  logic [2:0]               op_rm,
    input  logic [PARAM_Fp_size-1:0] op_a,
    input  logic [PARAM_Fp_size-1:0] op_b,
    input  logic [2:0]               frm,
    output logic                     add_req,
    output logic [2:0]               add_rm,
    output logic [PARAM_Fp_size-1:0] add_a,
    output logic [PARAM_Fp_size-1:0] add_b,
    input  logic                     add_valid,
    input  logic [PARAM_Fp_size-1:0] add_out,
    output logic                     wb_valid,
    input  logic                     wb_ready,
    output logic [4:0]               wb_rd,
    output logic [PARAM_Fp_size-1:0] wb_data,
    output logic                     wb_illegal,
    output logic                     wb_timeout,
    output logic                     err_stray
);

    localparam int W  = PARAM_Fp_size;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] QNAN = W'(32'h7FC0_0000);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

    state_t          state_q, state_d;
    logic [4:0]      rd_q, rd_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, data_q, data_d;
    logic [2:0]      rm_q, rm_d;
    logic            ill_q, ill_d, to_q, to_d, stray_q, stray_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      rm_res;

    assign rm_res = (op_rm == 3'b111) ? frm : op_rm;

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        a_d     = a_q;
        b_d     = b_q;
        rm_d    = rm_q;
        data_d  = data_q;
        ill_d   = ill_q;
        to_d    = to_q;
        cnt_d   = cnt_q;
        // The adder only ever answers in WAIT; anything else is a protocol error.
        stray_d = stray_q | (add_valid && (state_q != WAIT));
        unique case (state_q)
            IDLE: begin
                if (op_valid) begin
                    rd_d   = op_rd;
                    a_d    = op_a;
                    b_d    = {op_b[W-1] ^ op_sub, op_b[W-2:0]};
                    rm_d   = rm_res;
                    data_d = '0;
                    ill_d  = 1'b0;
                    to_d   = 1'b0;
                    cnt_d  = '0;
                    if (rm_res inside {3'b101, 3'b110, 3'b111}) begin
                        ill_d   = 1'b1;
                        state_d = WB;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (add_valid) begin
                    data_d  = add_out;
                    state_d = WB;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(TIMEOUT - 1)) begin
                        data_d  = QNAN;
                        to_d    = 1'b1;
                        state_d = WB;
                    end
                end
            end
            WB: begin
                if (wb_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rd_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rm_q    <= '0;
            data_q  <= '0;
            ill_q   <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
            stray_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rm_q    <= rm_d;
            data_q  <= data_d;
            ill_q   <= ill_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
            stray_q <= stray_d;
        end
    end

    assign op_ready   = (state_q == IDLE) && !rst;
    assign add_req    = (state_q == ISSUE);
    assign add_a      = a_q;
    assign add_b      = b_q;
    assign add_rm     = rm_q;
    assign wb_valid   = (state_q == WB);
    assign wb_rd      = rd_q;
    assign wb_data    = data_q;
    assign wb_illegal = ill_q;
    assign wb_timeout = to_q;
    assign err_stray  = stray_q;

endmodule

// File: doc/fpu_add_issue_ctrl.md
FPU_ADD_ISSUE_CTRL -- requirements
Module: fpu_add_issue_ctrl

Interface
REQ-001 SHALL have parameter PARAM_Fp_size, default 32, meaning operand/result width.
REQ-002 SHALL have parameter TIMEOUT, default 4, meaning maximum cycles spent in WAIT before abort.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports op_valid input 1, op_ready output 1, op_rd input 5, op_sub input 1, op_rm input 3, op_a input PARAM_Fp_size, op_b input PARAM_Fp_size  core request channel.
REQ-006 SHALL have port frm  input  3  dynamic rounding mode from the FCSR.
REQ-007 SHALL have ports add_req output 1, add_rm output 3, add_a output PARAM_Fp_size, add_b output PARAM_Fp_size  adder request side.
REQ-008 SHALL have ports add_valid input 1, add_out input PARAM_Fp_size  adder response side.
REQ-009 SHALL have ports wb_valid output 1, wb_ready input 1, wb_rd output 5, wb_data output PARAM_Fp_size, wb_illegal output 1, wb_timeout output 1  writeback channel.
REQ-010 SHALL have port err_stray  output  1  sticky flag for an unexpected add_valid.

Function
REQ-011 SHALL implement states IDLE, ISSUE, WAIT and WB, and nothing else.
REQ-012 SHALL drive op_ready=1 only in IDLE; an op is accepted when op_valid&op_ready.
REQ-013 On accept, SHALL register op_rd, op_a and op_b with bit [PARAM_Fp_size-1] XOR op_sub, plus the resolved rm: frm if op_rm==3'b111, else op_rm.
REQ-014 If the resolved rm is in {101,110,111}, SHALL go IDLE->WB with wb_illegal=1 and wb_data=0, and SHALL NOT assert add_req.
REQ-015 Otherwise SHALL go IDLE->ISSUE.
REQ-016 In ISSUE, SHALL assert add_req for exactly one cycle, with add_a/add_b/add_rm driven from the registers, then go to WAIT with the timeout counter cleared.
REQ-017 add_a, add_b and add_rm SHALL hold stable from ISSUE through WAIT.
REQ-018 In WAIT, add_valid=1 SHALL capture add_out into wb_data and go to WB with wb_illegal=0 and wb_timeout=0.
REQ-019 In WAIT, the counter SHALL increment each cycle without add_valid; on reaching TIMEOUT, SHALL go to WB with wb_timeout=1 and wb_data=32'h7FC0_0000.
REQ-020 add_valid arriving in the same cycle the counter reaches TIMEOUT SHALL take priority, giving a normal capture.
REQ-021 In WB, SHALL assert wb_valid and hold wb_rd/wb_data/flags stable until wb_ready=1, then go to IDLE.
REQ-022 wb_ready while wb_valid=0 SHALL be ignored.
REQ-023 add_valid in IDLE, ISSUE or WB SHALL be ignored for data and SHALL set err_stray, which is cleared only by reset.
REQ-024 With wb_ready held high, latency SHALL be 3 cycles from the accept edge to wb_valid (1-cycle adder); an illegal rm SHALL give wb_valid 1 cycle after accept.
REQ-025 Back-to-back: the earliest next accept SHALL be the cycle after the WB handshake.

Reset
REQ-026 While rst=1, SHALL force state=IDLE, with op_ready, add_req, wb_valid, wb_illegal, wb_timeout and err_stray at 0, and all data registers and the counter at 0.
REQ-027 Reset asserted mid-operation (ISSUE/WAIT/WB) SHALL abandon the op without a writeback; a late add_valid after reset SHALL set err_stray.
REQ-028 op_ready SHALL rise in the first cycle after rst deasserts.

Verification
REQ-029 Normal add: op_a=3FA00000, op_b=3FB00000, op_sub=0, op_rm=000, op_rd=5, with the real adder -> one add_req pulse, wb_data=40280000, wb_rd=5, wb_valid 3 cycles after accept.
REQ-030 Subtract: op_a=3FA00000, op_b=3FC00000, op_sub=1 -> add_b=BFC00000, wb_data=BE800000.
REQ-031 Dynamic rm: op_rm=111, frm=001 -> add_rm=001; op_rm=111, frm=101 -> no add_req, wb_illegal=1, wb_data=0, wb_valid 1 cycle after accept.
REQ-032 Timeout: adder stub never responds, TIMEOUT=4 -> wb_timeout=1, wb_data=7FC00000 after 4 WAIT cycles; a stub responding in the 4th WAIT cycle -> normal capture.
REQ-033 Backpressure: wb_ready low for 5 cycles -> wb_valid and wb_data stable, op_ready=0 throughout, single handshake.
REQ-034 Reset in WAIT, followed by a stub add_valid -> no wb_valid, err_stray=1, and the next op completes normally.
